// File: rtl/alu_arb_pkg.sv
// ----------------------------------------------------------------------------
// alu_arb_pkg
//
// Shared definitions for the ALU arbiter slice.
//   - arb_state_t      : binary state encoding of the arbiter sequencer
//   - ALU_*_W          : widths of the ALU datapath (operands, opcode, result)
//   - DEFAULT_TIMEOUT  : default WAIT abort limit in cycles
//   - idx_width()      : width of an index into N requesters (at least 1 bit)
// ----------------------------------------------------------------------------
package alu_arb_pkg;

    localparam int ALU_DATA_W      = 16;
    localparam int ALU_OPC_W       = 4;
    localparam int ALU_OUT_W       = 32;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [2:0] {
        ST_REARM   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4
    } arb_state_t;

    // A single requester still needs a 1-bit index so ports never collapse
    // to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational circular-priority arbiter. The search starts at the
// requester after 'last' and wraps around, so the most recently served
// requester has the lowest priority.
//
// Ports:
//   req   [N-1:0]   in   request vector
//   last  [LW-1:0]  in   index of the most recently granted requester
//   grant [N-1:0]   out  one-hot grant (all zero when no request is pending)
// ----------------------------------------------------------------------------
module rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int LW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  grant
);

    logic          found;
    logic [LW-1:0] idx;

    // Walk the N positions starting at last+1; the first pending request
    // wins and blocks every later position in the same walk.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = LW'((int'(last) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one ALU between N requesters. One operation at a time is accepted
// through a valid/ready handshake, its operands are latched, and the ALU is
// sequenced through start, wait-for-done, result capture and a re-arm reset
// pulse. The result goes back to the originating requester with a one-cycle
// strobe. A WAIT that exceeds TIMEOUT cycles is aborted with an error flag.
//
// Parameters:
//   N          number of requesters (2..8)
//   TIMEOUT    max cycles spent in WAIT before abort (1..65535)
//   REARM_CYC  minimum cycles alu_reset is held between operations (>=1)
//
// Ports:
//   clk                    in   clock, rising edge
//   reset_a                in   asynchronous reset, active low
//   req_valid  [N-1:0]     in   per-requester operation request
//   req_ready  [N-1:0]     out  one-hot accept, only in IDLE
//   req_dataa  [16N-1:0]   in   operand A, requester i at [16i+15:16i]
//   req_datab  [16N-1:0]   in   operand B, same packing
//   req_opcode [4N-1:0]    in   opcode, requester i at [4i+3:4i]
//   rsp_valid  [N-1:0]     out  one-hot, one-cycle result strobe
//   rsp_out    [31:0]      out  result, valid with rsp_valid
//   rsp_carry, rsp_zero    out  ALU flags, valid with rsp_valid
//   rsp_err                out  timeout abort, valid with rsp_valid
//   alu_dataa, alu_datab   out  operands to the ALU
//   alu_opcode             out  opcode to the ALU
//   alu_start              out  one-cycle start pulse to the ALU
//   alu_reset              out  ALU reset, active high
//   alu_out                in   ALU result
//   alu_carry, alu_zero    in   ALU flags
//   alu_done               in   ALU completion
// ----------------------------------------------------------------------------
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N         = 2,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int REARM_CYC = 1
) (
    input  logic                      clk,
    input  logic                      reset_a,
    input  logic [N-1:0]              req_valid,
    output logic [N-1:0]              req_ready,
    input  logic [ALU_DATA_W*N-1:0]   req_dataa,
    input  logic [ALU_DATA_W*N-1:0]   req_datab,
    input  logic [ALU_OPC_W*N-1:0]    req_opcode,
    output logic [N-1:0]              rsp_valid,
    output logic [ALU_OUT_W-1:0]      rsp_out,
    output logic                      rsp_carry,
    output logic                      rsp_zero,
    output logic                      rsp_err,
    output logic [ALU_DATA_W-1:0]     alu_dataa,
    output logic [ALU_DATA_W-1:0]     alu_datab,
    output logic [ALU_OPC_W-1:0]      alu_opcode,
    output logic                      alu_start,
    output logic                      alu_reset,
    input  logic [ALU_OUT_W-1:0]      alu_out,
    input  logic                      alu_carry,
    input  logic                      alu_zero,
    input  logic                      alu_done
);

    localparam int LW = idx_width(N);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(REARM_CYC + 1);

    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT);
    localparam logic [RW-1:0] REARM_LAST = RW'(REARM_CYC - 1);
    localparam logic [LW-1:0] LAST_INIT  = LW'(N - 1);

    arb_state_t state, state_next;

    logic [N-1:0]            grant;
    logic [LW-1:0]           grant_idx;
    logic [ALU_DATA_W-1:0]   grant_a;
    logic [ALU_DATA_W-1:0]   grant_b;
    logic [ALU_OPC_W-1:0]    grant_op;
    logic                    accept;

    logic [LW-1:0]           last;
    logic [LW-1:0]           owner;
    logic [TW-1:0]           tmo_cnt;
    logic [RW-1:0]           rearm_cnt;
    logic                    tmo_hit;
    logic                    done_hit;

    logic [ALU_DATA_W-1:0]   lat_a;
    logic [ALU_DATA_W-1:0]   lat_b;
    logic [ALU_OPC_W-1:0]    lat_op;
    logic [ALU_OUT_W-1:0]    res_out;
    logic                    res_carry;
    logic                    res_zero;
    logic                    res_err;

    rr_arbiter #(
        .N  (N),
        .LW (LW)
    ) u_rr (
        .req   (req_valid),
        .last  (last),
        .grant (grant)
    );

    // Turn the one-hot grant into an index and pick that requester's
    // operands out of the packed buses.
    always_comb begin
        grant_idx = '0;
        grant_a   = '0;
        grant_b   = '0;
        grant_op  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = LW'(i);
                grant_a   = req_dataa[i*ALU_DATA_W +: ALU_DATA_W];
                grant_b   = req_datab[i*ALU_DATA_W +: ALU_DATA_W];
                grant_op  = req_opcode[i*ALU_OPC_W +: ALU_OPC_W];
            end
        end
    end

    assign accept = |(req_valid & req_ready);

    // alu_done only counts in WAIT; a done already high during ISSUE is
    // ignored. A real done in the same cycle the limit is reached wins.
    assign done_hit = (state == ST_WAIT) && alu_done;
    assign tmo_hit  = (state == ST_WAIT) && !alu_done && (tmo_cnt == TMO_MAX);

    // State register. Reset lands in REARM so the ALU is held in reset
    // and any in-flight operation is dropped without a response.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state <= ST_REARM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        alu_start  = 1'b0;
        alu_reset  = 1'b0;
        unique case (state)
            ST_REARM: begin
                alu_reset = 1'b1;
                // Leaving while the ALU still reports done would let a
                // stale done complete the next operation immediately.
                if ((rearm_cnt == REARM_LAST) && !alu_done) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                req_ready = grant;
                if (accept) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_start  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_hit || tmo_hit) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                rsp_valid[owner] = 1'b1;
                state_next       = ST_REARM;
            end
            default: begin
                state_next = ST_REARM;
            end
        endcase
    end

    // Re-arm hold counter: counts REARM cycles and saturates at the last
    // required cycle, so a long stuck done cannot wrap it.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            rearm_cnt <= '0;
        end else if (state != ST_REARM) begin
            rearm_cnt <= '0;
        end else if (rearm_cnt != REARM_LAST) begin
            rearm_cnt <= rearm_cnt + 1'b1;
        end
    end

    // Timeout counter: cleared in ISSUE so the first WAIT cycle sees 0,
    // which puts the abort strobe exactly TIMEOUT+1 cycles after WAIT entry.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            tmo_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            tmo_cnt <= '0;
        end else if ((state == ST_WAIT) && !alu_done && (tmo_cnt != TMO_MAX)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Request latches. They only change on accept, which keeps the ALU
    // inputs stable from ISSUE through CAPTURE even while new requests
    // are queued on the input buses.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            lat_a  <= '0;
            lat_b  <= '0;
            lat_op <= '0;
            owner  <= '0;
            last   <= LAST_INIT;
        end else if (accept) begin
            lat_a  <= grant_a;
            lat_b  <= grant_b;
            lat_op <= grant_op;
            owner  <= grant_idx;
            last   <= grant_idx;
        end
    end

    // Result capture. A timeout replaces the result with zeros and sets
    // the error flag; a normal completion clears the flag again.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            res_out   <= '0;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
            res_err   <= 1'b0;
        end else if (done_hit) begin
            res_out   <= alu_out;
            res_carry <= alu_carry;
            res_zero  <= alu_zero;
            res_err   <= 1'b0;
        end else if (tmo_hit) begin
            res_out   <= '0;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
            res_err   <= 1'b1;
        end
    end

    assign alu_dataa  = lat_a;
    assign alu_datab  = lat_b;
    assign alu_opcode = lat_op;
    assign rsp_out    = res_out;
    assign rsp_carry  = res_carry;
    assign rsp_zero   = res_zero;
    assign rsp_err    = res_err;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin controller that shares one `alu_top` instance between `N` requesters. Accepts one operation at a time via a valid/ready handshake, latches its operands and sequences the ALU through start, wait-for-done, result capture and ALU re-arm (reset pulse). Returns the result with a one-cycle response strobe to the originating requester. Sits between client blocks and the ALU datapath.

## Interface
Parameters:
- `N`, 2, number of requesters (2..8)
- `TIMEOUT`, 255, max cycles in WAIT before the operation is aborted (1..65535)
- `REARM_CYC`, 1, minimum cycles `alu_reset` is held high between operations (≥1)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset_a`  in  1  asynchronous, active-low reset
- `req_valid`  in  N  per-requester operation request
- `req_ready`  out  N  one-hot accept; high only for the granted requester in IDLE
- `req_dataa`  in  16·N  operand A, requester i at [16i+15:16i]
- `req_datab`  in  16·N  operand B, same packing
- `req_opcode`  in  4·N  opcode, requester i at [4i+3:4i]
- `rsp_valid`  out  N  one-hot, one-cycle result strobe to the owning requester
- `rsp_out`  out  32  result, valid with `rsp_valid`
- `rsp_carry`, `rsp_zero`  out  1 each  ALU flags, valid with `rsp_valid`
- `rsp_err`  out  1  timeout abort, valid with `rsp_valid`
- `alu_dataa`, `alu_datab`  out  16 each  to ALU
- `alu_opcode`  out  4  to ALU
- `alu_start`  out  1  to ALU
- `alu_reset`  out  1  to ALU reset (active-high)
- `alu_out`  in  32; `alu_carry`, `alu_zero`, `alu_done`  in  1 each  from ALU

## Operation
- States: REARM, IDLE, ISSUE, WAIT, CAPTURE.
- REARM: `alu_reset`=1; leave to IDLE once `REARM_CYC` cycles elapsed AND `alu_done`=0.
- IDLE: grant = first i with `req_valid[i]`, scanning from `last+1` mod N circularly; `req_ready[grant]`=1 combinationally. On accept (valid&ready) latch operands, opcode and owner index, `last`←grant, go ISSUE. No request: stay.
- ISSUE: `alu_start`=1 for exactly one cycle; go WAIT, clear timeout counter.
- WAIT: `alu_start`=0; on `alu_done`=1 latch `alu_out`/flags, go CAPTURE. Counter reaching `TIMEOUT` without done: set err, result 0, flags 0, go CAPTURE.
- CAPTURE: `rsp_valid[owner]`=1 one cycle with registered result; go REARM.
- `alu_dataa/datab/opcode` driven from latches, stable from ISSUE through CAPTURE; 0 after reset.
- Requester must hold valid and operands until accepted; dropping valid before accept is legal (no grant).
- `req_ready` all 0 outside IDLE; new requests wait, never lost or reordered per requester.
- Async reset (`reset_a`=0): state→REARM, `last`←N-1 (requester 0 first priority), all outputs 0 except `alu_reset`=1. Reset mid-operation aborts silently: no `rsp_valid` issued.

## Timing
- Accept at cycle T → `alu_start` high T+1 → WAIT from T+2.
- `alu_done` sampled high at cycle D → `rsp_valid` high D+1 → `alu_reset` high D+2 for ≥`REARM_CYC` cycles → IDLE earliest D+2+`REARM_CYC`.
- Back-to-back throughput: one op per (ALU latency + 3 + `REARM_CYC`) cycles.
- Timeout: `rsp_err` strobe exactly `TIMEOUT`+1 cycles after WAIT entry.
- `alu_done` high already in ISSUE is ignored; only WAIT samples it.

## Structure
- Package `alu_arb_pkg`: state encoding (5 states, binary), ALU width constants (16/16/4/32), default `TIMEOUT`.
- Sub-module `rr_arbiter` (N, `req`, `last`, one-hot `grant`): pure combinational circular priority; instantiated once.
- Timeout counter width = clog2(`TIMEOUT`+1).

## Test plan
- Reset then single request: req0 a=0x0008, b=0x0002, op=0000 → `alu_start` one cycle after accept; `rsp_valid`=01, `rsp_out`=ALU result, then `alu_reset` pulse.
- Simultaneous persistent req0+req1 (N=2) → grants alternate 0,1,0,1; each `rsp_valid` goes only to its owner.
- Request arriving during WAIT → `req_ready` stays 0 until IDLE, then accepted; operands at ALU unchanged during first op.
- ALU model never raises done, `TIMEOUT`=16 → `rsp_err`=1, `rsp_out`=0 at WAIT+17, then REARM and next request served.
- `reset_a` low mid-WAIT → `alu_reset`=1 immediately, no `rsp_valid`; after release one REARM cycle, then req0 has priority.
- `alu_done` held high after capture → arbiter stays in REARM until done falls, no second response.
